// File: rtl/usr_ctrl.sv
// usr_ctrl: command sequencer that drives a universal shift register's sel/SI/PI for n cycles
module usr_ctrl #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [2:0]       i_cmd_op,
    input  logic [CNT_W-1:0] i_cmd_amt,
    input  logic [WIDTH-1:0] i_cmd_data,
    input  logic             i_cmd_fill,
    output logic [1:0]       o_usr_sel,
    output logic             o_usr_si,
    output logic [WIDTH-1:0] o_usr_pi,
    input  logic [WIDTH-1:0] i_usr_po,
    input  logic             i_usr_so,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_data,
    output logic             o_rsp_err
);
    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_SHL  = 3'd1;
    localparam logic [2:0] OP_SHR  = 3'd2;
    localparam logic [2:0] OP_ROL  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_fill;
    logic [CNT_W-1:0] w_n;
    logic [1:0]       w_exec_sel;
    logic             w_accept;
    logic             w_shift_op;

    assign w_accept   = (r_state == S_IDLE) && i_cmd_valid;
    assign w_shift_op = (i_cmd_op >= OP_SHL) && (i_cmd_op <= OP_ROR);
    // READ and illegal ops need no register cycles and go straight to the response
    assign w_n        = (i_cmd_op == OP_LOAD) ? CNT_W'(1) : w_shift_op ? i_cmd_amt : '0;
    assign w_exec_sel = (r_op == OP_LOAD) ? 2'b11 :
                        (r_op == OP_SHL || r_op == OP_ROL) ? 2'b01 :
                        (r_op == OP_SHR || r_op == OP_ROR) ? 2'b10 : 2'b00;
    // rotates feed the exiting bit back in; plain shifts use the latched fill
    assign o_usr_si   = (r_op == OP_SHL || r_op == OP_SHR) ? r_fill :
                        (r_op == OP_ROL || r_op == OP_ROR) ? i_usr_so : 1'b0;
    assign o_usr_pi   = r_data;
    assign o_rsp_data = i_usr_po;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // command latch and remaining-cycle down-counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= '0;
            r_cnt  <= '0;
            r_data <= '0;
            r_fill <= 1'b0;
        end else if (w_accept) begin
            r_op   <= i_cmd_op;
            r_cnt  <= w_n;
            r_data <= i_cmd_data;
            r_fill <= i_cmd_fill;
        end else if (r_state == S_EXEC) begin
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

    // next state and handshake / register control outputs
    always_comb begin
        w_next      = r_state;
        o_cmd_ready = 1'b0;
        o_usr_sel   = 2'b00;
        o_rsp_valid = 1'b0;
        o_rsp_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) w_next = (w_n == '0) ? S_RESP : S_EXEC;
            end
            S_EXEC: begin
                o_usr_sel = w_exec_sel;
                if (r_cnt == CNT_W'(1)) w_next = S_RESP;
            end
            S_RESP: begin
                o_rsp_valid = 1'b1;
                o_rsp_err   = r_op[2] & r_op[1];
                if (i_rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_usr_ctrl.sv
// tb_usr_ctrl: self-checking bench for usr_ctrl with a behavioural shift register attached
module tb_usr_ctrl;
    localparam int W = 5;

    logic         clk, rst;
    logic         cmd_valid, cmd_ready, cmd_fill;
    logic [2:0]   cmd_op, cmd_amt;
    logic [W-1:0] cmd_data;
    logic [1:0]   usr_sel;
    logic         usr_si, usr_so;
    logic [W-1:0] usr_pi, usr_po;
    logic         rsp_valid, rsp_ready, rsp_err;
    logic [W-1:0] rsp_data;

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] m_word;

    usr_ctrl #(.WIDTH(W), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
        .i_cmd_amt(cmd_amt), .i_cmd_data(cmd_data), .i_cmd_fill(cmd_fill),
        .o_usr_sel(usr_sel), .o_usr_si(usr_si), .o_usr_pi(usr_pi),
        .i_usr_po(usr_po), .i_usr_so(usr_so),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data), .o_rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // universal shift register being controlled: 01 left, 10 right, 11 load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) usr_po <= '0;
        else case (usr_sel)
            2'b01: usr_po <= {usr_po[W-2:0], usr_si};
            2'b10: usr_po <= {usr_si, usr_po[W-1:1]};
            2'b11: usr_po <= usr_pi;
            default: ;
        endcase
    end
    assign usr_so = (usr_sel == 2'b01) ? usr_po[W-1] : usr_po[0];

    typedef struct {
        logic [2:0]   op;
        logic [2:0]   amt;
        logic [W-1:0] data;
        logic         fill;
        int           hold;
        bit           keep;
        logic [W-1:0] x_data;
        logic         x_err;
        int           x_lat;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [1:0] exec_sel(input logic [2:0] op);
        case (op)
            3'd0:       return 2'b11;
            3'd1, 3'd3: return 2'b01;
            3'd2, 3'd4: return 2'b10;
            default:    return 2'b00;
        endcase
    endfunction

    function automatic int cycles_for(input logic [2:0] op, input int amt);
        if (op == 3'd0) return 1;
        if (op >= 3'd1 && op <= 3'd4) return amt;
        return 0;
    endfunction

    // word-level result of a command, computed with whole-word arithmetic
    function automatic logic [W-1:0] ref_word(input logic [W-1:0] x, input logic [2:0] op,
                                              input int amt, input logic [W-1:0] d, input logic f);
        int full = (1 << W) - 1;
        int xi   = int'(x);
        int fb   = f ? full : 0;
        int r    = amt % W;
        case (op)
            3'd0: return d;
            3'd1: return (amt >= W) ? W'(fb) : W'(((xi << amt) | (fb >> (W - amt))) & full);
            3'd2: return (amt >= W) ? W'(fb) : W'(((xi >> amt) | ((fb << (W - amt)) & full)) & full);
            3'd3: return W'(((xi << r) | (xi >> (W - r))) & full);
            3'd4: return W'(((xi >> r) | (xi << (W - r))) & full);
            default: return x;
        endcase
    endfunction

    task automatic do_cmd(input logic [2:0] op, input logic [2:0] amt, input logic [W-1:0] data,
                          input logic fill, input int hold, input bit keep, input bit early,
                          input logic [W-1:0] x_data, input logic x_err, input int x_lat,
                          input string tag);
        int           cyc, sel_cnt, bad;
        logic [1:0]   xs;
        logic [W-1:0] held;
        xs = exec_sel(op);
        chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_amt = amt; cmd_data = data; cmd_fill = fill;
        @(posedge clk); #1;
        if (keep) begin
            cmd_op = 3'd0; cmd_data = '1;
        end else cmd_valid = 1'b0;
        rsp_ready = early;
        cyc = 1; sel_cnt = 0; bad = 0;
        while (!rsp_valid && cyc < 40) begin
            if (usr_sel != 2'b00) sel_cnt++;
            if (usr_sel != xs || cmd_ready || (xs == 2'b11 && usr_pi != data)) bad++;
            @(posedge clk); #1; cyc++;
        end
        rsp_ready = 1'b0;
        chk({tag, "_latency"}, cyc, x_lat);
        chk({tag, "_sel_cycles"}, sel_cnt, x_lat - 1);
        chk({tag, "_exec_bad"}, bad, 0);
        chk({tag, "_rsp_data"}, int'(rsp_data), int'(x_data));
        chk({tag, "_rsp_err"}, int'(rsp_err), int'(x_err));
        held = rsp_data;
        bad = 0;
        repeat (hold) begin
            if (!rsp_valid || rsp_data != held || cmd_ready || usr_sel != 2'b00) bad++;
            @(posedge clk); #1;
        end
        if (hold > 0) chk({tag, "_hold_bad"}, bad, 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk({tag, "_post_ready"}, int'(cmd_ready), 1);
        chk({tag, "_post_valid"}, int'(rsp_valid), 0);
        m_word = x_data;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]   r_op, r_amt;
        logic [W-1:0] r_data, x;
        logic         r_fill;
        tbl[0]  = '{3'd0, 3'd0, 5'b10110, 1'b0, 0, 1'b0, 5'b10110, 1'b0, 2};
        tbl[1]  = '{3'd3, 3'd2, 5'b00000, 1'b0, 0, 1'b0, 5'b11010, 1'b0, 3};
        tbl[2]  = '{3'd4, 3'd1, 5'b00000, 1'b0, 1, 1'b0, 5'b01101, 1'b0, 2};
        tbl[3]  = '{3'd0, 3'd0, 5'b00011, 1'b0, 0, 1'b0, 5'b00011, 1'b0, 2};
        tbl[4]  = '{3'd1, 3'd3, 5'b00000, 1'b1, 0, 1'b0, 5'b11111, 1'b0, 4};
        tbl[5]  = '{3'd2, 3'd7, 5'b11111, 1'b0, 0, 1'b0, 5'b00000, 1'b0, 8};
        tbl[6]  = '{3'd0, 3'd0, 5'b01010, 1'b0, 0, 1'b0, 5'b01010, 1'b0, 2};
        tbl[7]  = '{3'd5, 3'd3, 5'b11111, 1'b1, 0, 1'b0, 5'b01010, 1'b0, 1};
        tbl[8]  = '{3'd6, 3'd4, 5'b11111, 1'b1, 0, 1'b0, 5'b01010, 1'b1, 1};
        tbl[9]  = '{3'd1, 3'd0, 5'b00000, 1'b1, 0, 1'b0, 5'b01010, 1'b0, 1};
        tbl[10] = '{3'd7, 3'd5, 5'b00000, 1'b0, 2, 1'b0, 5'b01010, 1'b1, 1};
        tbl[11] = '{3'd3, 3'd5, 5'b00000, 1'b0, 0, 1'b0, 5'b01010, 1'b0, 6};
        tbl[12] = '{3'd5, 3'd0, 5'b00000, 1'b0, 4, 1'b1, 5'b01010, 1'b0, 1};
        tbl[13] = '{3'd1, 3'd6, 5'b00000, 1'b1, 0, 1'b0, 5'b11111, 1'b0, 7};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_amt = '0; cmd_data = '0;
        cmd_fill = 1'b0; rsp_ready = 1'b0; m_word = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("in_reset_sel", int'(usr_sel), 0);
        chk("in_reset_rsp_valid", int'(rsp_valid), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_cmd_ready", int'(cmd_ready), 1);
        chk("reset_sel", int'(usr_sel), 0);
        chk("reset_si", int'(usr_si), 0);
        chk("reset_pi", int'(usr_pi), 0);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_err", int'(rsp_err), 0);
        chk("reset_rsp_data", int'(rsp_data), 0);

        for (int i = 0; i < 14; i++)
            do_cmd(tbl[i].op, tbl[i].amt, tbl[i].data, tbl[i].fill, tbl[i].hold, tbl[i].keep,
                   tbl[i].keep, tbl[i].x_data, tbl[i].x_err, tbl[i].x_lat, $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            r_op   = 3'($urandom_range(0, 7));
            r_amt  = 3'($urandom_range(0, 7));
            r_data = W'($urandom);
            r_fill = 1'($urandom);
            x      = ref_word(m_word, r_op, int'(r_amt), r_data, r_fill);
            do_cmd(r_op, r_amt, r_data, r_fill, $urandom_range(0, 2), 1'b0, 1'($urandom),
                   x, r_op >= 3'd6, cycles_for(r_op, int'(r_amt)) + 1, $sformatf("rnd%0d", i));
        end

        do_cmd(3'd0, 3'd0, 5'b10110, 1'b0, 0, 1'b0, 1'b0, 5'b10110, 1'b0, 2, "pre_abort_load");
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_amt = 3'd5; cmd_data = '0; cmd_fill = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_mid_sel", int'(usr_sel), 2);
        rst = 1'b1;
        #1;
        chk("abort_async_sel", int'(usr_sel), 0);
        chk("abort_async_rsp_valid", int'(rsp_valid), 0);
        chk("abort_reg_cleared", int'(rsp_data), 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_cmd_ready", int'(cmd_ready), 1);
        chk("abort_idle_sel", int'(usr_sel), 0);
        chk("abort_idle_rsp_valid", int'(rsp_valid), 0);
        m_word = '0;
        do_cmd(3'd5, 3'd0, 5'b00000, 1'b0, 0, 1'b0, 1'b0, 5'b00000, 1'b0, 1, "post_abort_read");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
